// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: default datapath widths and the ALU opcode encoding.
package id_ex_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 4;

    // ALU opcode encoding shared with the decoder and the ALU
    localparam logic [7:0] OP_EMPTY = 8'h0B;
    localparam logic [7:0] OP_ADD   = 8'h19;

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Per-operand bypass selector: EX/MEM result beats MEM/WB data, which beats the register file.
module forward_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              use_reg,
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd_addr,
    input  logic [DATA_W-1:0] mw_data,
    output logic [DATA_W-1:0] data
);

    // A load in EX/MEM has no data yet, so it must not be bypassed from that stage
    always_comb begin
        data = rf_data;
        if (use_reg) begin
            if (exm_reg_write && !exm_mem_read && (exm_rd_addr == addr)) begin
                data = exm_result;
            end else if (mw_reg_write && (mw_rd_addr == addr)) begin
                data = mw_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [7:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd_addr,
    input  logic [DATA_W-1:0] mw_data,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [7:0]        ex_opcode,
    output logic [DATA_W-1:0] ex_input1,
    output logic [DATA_W-1:0] ex_input2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    logic [REG_AW-1:0] ex_rs_addr, ex_rt_addr;
    logic              ex_use_rs, ex_use_rt, ex_use_imm;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    logic              nxt_valid, nxt_use_rs, nxt_use_rt, nxt_use_imm;
    logic              nxt_reg_write, nxt_mem_read, nxt_mem_write;
    logic [7:0]        nxt_opcode;
    logic [REG_AW-1:0] nxt_rs_addr, nxt_rt_addr, nxt_rd_addr;
    logic [DATA_W-1:0] nxt_rs_data, nxt_rt_data, nxt_imm;

    assign load_use_stall = ex_valid && ex_mem_read && ex_reg_write && id_valid &&
                            ((id_use_rs && (id_rs_addr == ex_rd_addr)) ||
                             (id_use_rt && (id_rt_addr == ex_rd_addr)));

    // Next contents default to a bubble; a real capture gates its controls with id_valid
    always_comb begin
        nxt_valid     = 1'b0;
        nxt_opcode    = OP_EMPTY;
        nxt_rs_addr   = '0;
        nxt_rt_addr   = '0;
        nxt_use_rs    = 1'b0;
        nxt_use_rt    = 1'b0;
        nxt_rs_data   = '0;
        nxt_rt_data   = '0;
        nxt_imm       = '0;
        nxt_use_imm   = 1'b0;
        nxt_rd_addr   = '0;
        nxt_reg_write = 1'b0;
        nxt_mem_read  = 1'b0;
        nxt_mem_write = 1'b0;
        if (!flush && !load_use_stall) begin
            nxt_valid     = id_valid;
            nxt_opcode    = id_valid ? id_opcode : OP_EMPTY;
            nxt_rs_addr   = id_rs_addr;
            nxt_rt_addr   = id_rt_addr;
            nxt_use_rs    = id_use_rs && id_valid;
            nxt_use_rt    = id_use_rt && id_valid;
            nxt_rs_data   = id_rs_data;
            nxt_rt_data   = id_rt_data;
            nxt_imm       = id_imm;
            nxt_use_imm   = id_use_imm && id_valid;
            nxt_rd_addr   = id_rd_addr;
            nxt_reg_write = id_reg_write && id_valid;
            nxt_mem_read  = id_mem_read && id_valid;
            nxt_mem_write = id_mem_write && id_valid;
        end
    end

    // flush overrides stall, so the register updates whenever either flush or no stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= OP_EMPTY;
            ex_rs_addr   <= '0;
            ex_rt_addr   <= '0;
            ex_use_rs    <= 1'b0;
            ex_use_rt    <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (flush || !stall) begin
            ex_valid     <= nxt_valid;
            ex_opcode    <= nxt_opcode;
            ex_rs_addr   <= nxt_rs_addr;
            ex_rt_addr   <= nxt_rt_addr;
            ex_use_rs    <= nxt_use_rs;
            ex_use_rt    <= nxt_use_rt;
            ex_rs_data   <= nxt_rs_data;
            ex_rt_data   <= nxt_rt_data;
            ex_imm       <= nxt_imm;
            ex_use_imm   <= nxt_use_imm;
            ex_rd_addr   <= nxt_rd_addr;
            ex_reg_write <= nxt_reg_write;
            ex_mem_read  <= nxt_mem_read;
            ex_mem_write <= nxt_mem_write;
        end
    end

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .use_reg       (ex_use_rs),
        .addr          (ex_rs_addr),
        .rf_data       (ex_rs_data),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mw_reg_write  (mw_reg_write),
        .mw_rd_addr    (mw_rd_addr),
        .mw_data       (mw_data),
        .data          (fwd_rs)
    );

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .use_reg       (ex_use_rt),
        .addr          (ex_rt_addr),
        .rf_data       (ex_rt_data),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mw_reg_write  (mw_reg_write),
        .mw_rd_addr    (mw_rd_addr),
        .mw_data       (mw_data),
        .data          (fwd_rt)
    );

    assign ex_input1     = fwd_rs;
    assign ex_input2     = ex_use_imm ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a stage model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, id_valid;
    logic [7:0]  id_opcode;
    logic [3:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_use_rs, id_use_rt, id_use_imm;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write, exm_mem_read;
    logic [3:0]  exm_rd_addr;
    logic [15:0] exm_result;
    logic        mw_reg_write;
    logic [3:0]  mw_rd_addr;
    logic [15:0] mw_data;
    logic        load_use_stall, ex_valid;
    logic [7:0]  ex_opcode;
    logic [15:0] ex_input1, ex_input2, ex_store_data;
    logic [3:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;

    // Model of the instruction sitting in EX
    logic        m_valid, m_use_rs, m_use_rt, m_use_imm, m_reg_write, m_mem_read, m_mem_write;
    logic [7:0]  m_opcode;
    logic [3:0]  m_rs, m_rt, m_rd;
    logic [15:0] m_rs_data, m_rt_data, m_imm;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mw_reg_write(mw_reg_write), .mw_rd_addr(mw_rd_addr), .mw_data(mw_data),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_input1(ex_input1), .ex_input2(ex_input2), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_fwd(input logic use_r, input logic [3:0] a,
                                            input logic [15:0] rf);
        if (!use_r) return rf;
        if (exm_reg_write && !exm_mem_read && exm_rd_addr == a) return exm_result;
        if (mw_reg_write && mw_rd_addr == a) return mw_data;
        return rf;
    endfunction

    function automatic logic ref_lus();
        return m_valid && m_mem_read && m_reg_write && id_valid &&
               ((id_use_rs && id_rs_addr == m_rd) || (id_use_rt && id_rt_addr == m_rd));
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_opcode = 8'h0B; m_rs = 0; m_rt = 0; m_rd = 0;
        m_use_rs = 0; m_use_rt = 0; m_use_imm = 0;
        m_rs_data = 0; m_rt_data = 0; m_imm = 0;
        m_reg_write = 0; m_mem_read = 0; m_mem_write = 0;
    endtask

    task automatic model_update();
        if (flush || (!stall && ref_lus())) begin
            model_bubble();
        end else if (!stall) begin
            m_valid = id_valid;
            m_opcode = id_valid ? id_opcode : 8'h0B;
            m_rs = id_rs_addr; m_rt = id_rt_addr; m_rd = id_rd_addr;
            m_use_rs = id_use_rs & id_valid;
            m_use_rt = id_use_rt & id_valid;
            m_use_imm = id_use_imm & id_valid;
            m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
            m_reg_write = id_reg_write & id_valid;
            m_mem_read = id_mem_read & id_valid;
            m_mem_write = id_mem_write & id_valid;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        stall = 0; flush = 0; id_valid = 0; id_opcode = 8'h0B;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
        id_use_rs = 0; id_use_rt = 0; id_use_imm = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exm_reg_write = 0; exm_mem_read = 0; exm_rd_addr = 0; exm_result = 0;
        mw_reg_write = 0; mw_rd_addr = 0; mw_data = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        model_bubble();
        #1;
        checks++;
        if (ex_opcode !== 8'h0B || ex_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_opcode_valid: got %h/%b expected 0b/0", ex_opcode, ex_valid);
        end
        checks++;
        if ({ex_input1, ex_input2, ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read,
             ex_mem_write, load_use_stall} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h %h %h %h %b%b%b%b expected all 0",
                     ex_input1, ex_input2, ex_store_data, ex_rd_addr,
                     ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall);
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_opcode !== 8'h0B || ex_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL nop_stream: got %h/%b expected 0b/0", ex_opcode, ex_valid);
            end
        end
    endtask

    task automatic test_exm_forward();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_rs_addr = 1; id_use_rs = 1; id_rs_data = 0;
        id_rd_addr = 5; id_reg_write = 1;
        tick();
        drive_idle();
        exm_reg_write = 1; exm_rd_addr = 1; exm_result = 16'h1234;
        #1;
        checks++;
        if (ex_input1 !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL exm_forward: got %h expected 1234", ex_input1);
        end
        checks++;
        if (ex_opcode !== 8'h19 || ex_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exm_forward_capture: got %h/%b expected 19/1", ex_opcode, ex_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_both_match();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_rt_addr = 2; id_use_rt = 1; id_rt_data = 0;
        tick();
        drive_idle();
        exm_reg_write = 1; exm_rd_addr = 2; exm_result = 16'hAAAA;
        mw_reg_write = 1; mw_rd_addr = 2; mw_data = 16'h5555;
        #1;
        checks++;
        if (ex_input2 !== 16'hAAAA) begin
            errors++;
            $display("[TB] FAIL both_match_exm: got %h expected aaaa", ex_input2);
        end
        exm_mem_read = 1;
        #1;
        checks++;
        if (ex_input2 !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL both_match_load: got %h expected 5555", ex_input2);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_use_rs = 1; id_rs_addr = 0;
        id_rd_addr = 3; id_reg_write = 1; id_mem_read = 1;
        tick();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_rs_addr = 3; id_use_rs = 1;
        id_rd_addr = 4; id_reg_write = 1;
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_use_detect: got %b expected 1", load_use_stall);
        end
        tick();
        exm_reg_write = 1; exm_mem_read = 1; exm_rd_addr = 3; exm_result = 16'h0DEF;
        #1;
        checks++;
        if (ex_opcode !== 8'h0B || ex_valid !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_use_bubble: got %h/%b/%b expected 0b/0/0",
                     ex_opcode, ex_valid, load_use_stall);
        end
        tick();
        exm_reg_write = 0; exm_mem_read = 0; exm_rd_addr = 0;
        mw_reg_write = 1; mw_rd_addr = 3; mw_data = 16'hBEEF;
        #1;
        checks++;
        if (ex_input1 !== 16'hBEEF || ex_opcode !== 8'h19 || ex_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_use_resume: got %h/%h/%b expected beef/19/1",
                     ex_input1, ex_opcode, ex_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_stall();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_rs_addr = 1; id_use_rs = 1; id_rs_data = 16'h0101;
        id_rd_addr = 6; id_reg_write = 1;
        tick();
        flush = 1; stall = 1; id_opcode = 8'h1A;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_opcode !== 8'h0B || ex_input1 !== 16'h0 || ex_reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_over_stall: got %b/%h/%h/%b expected 0/0b/0000/0",
                     ex_valid, ex_opcode, ex_input1, ex_reg_write);
        end
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_rs_addr = 2; id_use_rs = 1; id_rs_data = 16'h2222;
        id_use_imm = 1; id_imm = 16'h0033; id_rd_addr = 7; id_reg_write = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            stall = 1;
            id_opcode = 8'h1A; id_rs_data = 16'($urandom); id_imm = 16'($urandom);
            id_rd_addr = 4'(i);
            tick();
            checks++;
            if (ex_opcode !== 8'h19 || ex_input1 !== 16'h2222 || ex_input2 !== 16'h0033 ||
                ex_rd_addr !== 4'd7 || ex_reg_write !== 1'b1 || ex_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold: got %h/%h/%h/%h/%b/%b expected 19/2222/0033/7/1/1",
                         ex_opcode, ex_input1, ex_input2, ex_rd_addr, ex_reg_write, ex_valid);
            end
        end
    endtask

    task automatic test_immediate();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_use_imm = 1; id_imm = 16'hFFF0;
        id_rt_addr = 5; id_use_rt = 1; id_rt_data = 16'h1111; id_mem_write = 1;
        tick();
        drive_idle();
        mw_reg_write = 1; mw_rd_addr = 5; mw_data = 16'h2222;
        #1;
        checks++;
        if (ex_input2 !== 16'hFFF0 || ex_store_data !== 16'h2222 || ex_mem_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL immediate: got %h/%h/%b expected fff0/2222/1",
                     ex_input2, ex_store_data, ex_mem_write);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        drive_idle();
        id_valid = 1; id_opcode = 8'h19; id_rd_addr = 9; id_reg_write = 1;
        tick();
        stall = 1;
        tick();
        #2;
        rst = 0;
        model_bubble();
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_opcode !== 8'h0B || ex_reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall: got %b/%h/%b expected 0/0b/0",
                     ex_valid, ex_opcode, ex_reg_write);
        end
        @(negedge clk);
        rst = 1;
        drive_idle();
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_opcode !== 8'h0B) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall_after: got %b/%h expected 0/0b", ex_valid, ex_opcode);
        end
    endtask

    task automatic test_random();
        logic [15:0] e1, e2, es;
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 8);
            id_valid = ($urandom_range(0, 99) < 80);
            id_opcode = 8'($urandom_range(8'h10, 8'h1F));
            id_rs_addr = 4'($urandom_range(0, 3)); id_rt_addr = 4'($urandom_range(0, 3));
            id_rd_addr = 4'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); id_use_imm = 1'($urandom);
            id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
            id_reg_write = 1'($urandom);
            id_mem_read = ($urandom_range(0, 99) < 35);
            id_mem_write = 1'($urandom);
            exm_reg_write = 1'($urandom); exm_mem_read = 1'($urandom);
            exm_rd_addr = 4'($urandom_range(0, 3)); exm_result = 16'($urandom);
            mw_reg_write = 1'($urandom); mw_rd_addr = 4'($urandom_range(0, 3));
            mw_data = 16'($urandom);
            #1;
            e1 = ref_fwd(m_use_rs, m_rs, m_rs_data);
            es = ref_fwd(m_use_rt, m_rt, m_rt_data);
            e2 = m_use_imm ? m_imm : es;
            checks++;
            if (load_use_stall !== ref_lus()) begin
                errors++;
                $display("[TB] FAIL rand_load_use[%0d]: got %b expected %b", n, load_use_stall, ref_lus());
            end
            checks++;
            if (ex_valid !== m_valid || ex_reg_write !== m_reg_write ||
                ex_mem_read !== m_mem_read || ex_mem_write !== m_mem_write) begin
                errors++;
                $display("[TB] FAIL rand_ctrl[%0d]: got %b%b%b%b expected %b%b%b%b", n,
                         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                         m_valid, m_reg_write, m_mem_read, m_mem_write);
            end
            if (m_valid) begin
                checks++;
                if (ex_opcode !== m_opcode || ex_rd_addr !== m_rd || ex_input1 !== e1 ||
                    ex_input2 !== e2 || ex_store_data !== es) begin
                    errors++;
                    $display("[TB] FAIL rand_data[%0d]: got %h/%h/%h/%h/%h expected %h/%h/%h/%h/%h", n,
                             ex_opcode, ex_rd_addr, ex_input1, ex_input2, ex_store_data,
                             m_opcode, m_rd, e1, e2, es);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 0;
        drive_idle();
        model_bubble();
        @(negedge clk);
        test_reset();
        test_exm_forward();
        test_both_match();
        test_load_use();
        test_flush_stall();
        test_immediate();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
